// File: rtl/omsp_atom_violation_log_if.sv
// Peripheral bus bundle for the atomicity violation logger (openMSP430 style).
interface omsp_atom_violation_log_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/omsp_atom_violation_log.sv
// Atomicity violation logger: captures each violation event (cause, SM ID, PC)
// into a small FIFO, raises an interrupt and/or a reset request, and exposes
// everything through an 8-word peripheral register window.
// Optional feature macro: ATOM_LOG_MAXWIN_EN builds the longest
// interrupt-masked window tracker (MAXWIN); without it MAXWIN reads 0.
module omsp_atom_violation_log #(
  parameter logic [13:0] BASE_ADDR = 14'h00C8,
  parameter int          DEPTH     = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        atom_violation,
  input  logic [1:0]  viol_cause,
  input  logic [15:0] sm_id,
  input  logic [15:0] inst_pc,
  input  logic        gie,
  omsp_atom_violation_log_if.slave per_bus,
  output logic        viol_irq,
  output logic        viol_reset_req
);
  localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  // Register window decode
  logic [13:0] reg_off;
  logic        in_win, bus_wr, bus_rd;
  logic        wr_ctrl, wr_pop, wr_maxwin, clr_stat;

  assign reg_off   = per_bus.per_addr - BASE_ADDR;
  assign in_win    = (reg_off < 14'd8);
  assign bus_wr    = per_bus.per_en & (|per_bus.per_we);
  assign bus_rd    = per_bus.per_en & ~(|per_bus.per_we);
  assign wr_ctrl   = bus_wr & in_win & (reg_off[2:0] == 3'd1);
  assign wr_pop    = bus_wr & in_win & (reg_off[2:0] == 3'd5);
  assign wr_maxwin = bus_wr & in_win & (reg_off[2:0] == 3'd6);
  assign clr_stat  = wr_ctrl & per_bus.per_din[2];

  // Event detection and FIFO control
  logic             viol_d, evt;
  logic [3:0]       count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, pop_ok, push_ok, drop_evt;
  logic             ovf, irq_en, rst_en;
  logic [3:0]       drop_cnt, drop_next;
  logic [15:0]      max_win;

  logic [1:0]  cause_mem [DEPTH];
  logic [15:0] smid_mem  [DEPTH];
  logic [15:0] pc_mem    [DEPTH];

  assign evt        = atom_violation & ~viol_d;
  assign fifo_empty = (count == 4'd0);
  assign fifo_full  = (count == FULL_CNT);
  // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
  // that a simultaneous push then takes.
  assign pop_ok     = wr_pop & ~fifo_empty;
  assign push_ok    = evt & (~fifo_full | pop_ok);
  assign drop_evt   = evt & ~push_ok;

  // Clear applies to the old value; a drop in the same cycle is still recorded
  always_comb begin
    drop_next = clr_stat ? 4'd0 : drop_cnt;
    if (drop_evt && (drop_next != 4'hF)) drop_next = drop_next + 4'd1;
  end

  // Edge detector, pointers and occupancy count
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      viol_d <= 1'b0;
      count  <= 4'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      viol_d <= atom_violation;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Record storage (data only, no reset needed)
  always_ff @(posedge mclk) begin
    if (push_ok) begin
      cause_mem[wr_ptr] <= viol_cause;
      smid_mem[wr_ptr]  <= sm_id;
      pc_mem[wr_ptr]    <= inst_pc;
    end
  end

  // Control bits, overflow status and the registered reset request
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      irq_en         <= 1'b0;
      rst_en         <= 1'b0;
      ovf            <= 1'b0;
      drop_cnt       <= 4'd0;
      viol_reset_req <= 1'b0;
    end else begin
      viol_reset_req <= evt & rst_en;
      if (wr_ctrl) begin
        irq_en <= per_bus.per_din[0];
        rst_en <= per_bus.per_din[1];
      end
      ovf      <= (ovf & ~clr_stat) | drop_evt;
      drop_cnt <= drop_next;
    end
  end

`ifdef ATOM_LOG_MAXWIN_EN
  logic [15:0] win_cnt;

  // Measure masked windows and fold each finished one into MAXWIN
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      win_cnt <= 16'd0;
      max_win <= 16'd0;
    end else begin
      if (!gie) begin
        if (win_cnt != 16'hFFFF) win_cnt <= win_cnt + 16'd1;
      end else begin
        win_cnt <= 16'd0;
      end
      if (wr_maxwin)                   max_win <= 16'd0;
      else if (gie && (win_cnt > max_win)) max_win <= win_cnt;
    end
  end
`else
  logic unused_maxwin;
  assign unused_maxwin = gie ^ wr_maxwin;
  assign max_win       = 16'd0;
`endif

  logic unused_din;
  assign unused_din = ^per_bus.per_din[15:3];

  assign viol_irq = irq_en & ~fifo_empty;

  // Combinational read mux; head registers read 0 while the FIFO is empty
  always_comb begin
    per_bus.per_dout = 16'd0;
    if (bus_rd && in_win) begin
      case (reg_off[2:0])
        3'd0:    per_bus.per_dout = {5'd0, rst_en, irq_en, drop_cnt, ovf, count};
        3'd1:    per_bus.per_dout = {14'd0, rst_en, irq_en};
        3'd2:    per_bus.per_dout = fifo_empty ? 16'd0 : {14'd0, cause_mem[rd_ptr]};
        3'd3:    per_bus.per_dout = fifo_empty ? 16'd0 : smid_mem[rd_ptr];
        3'd4:    per_bus.per_dout = fifo_empty ? 16'd0 : pc_mem[rd_ptr];
        3'd6:    per_bus.per_dout = max_win;
        default: per_bus.per_dout = 16'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_omsp_atom_violation_log.sv
// Bench for omsp_atom_violation_log: directed scenarios plus randomized
// traffic checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_omsp_atom_violation_log;
  localparam logic [13:0] BASE  = 14'h00C8;
  localparam int          DEPTH = 4;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        atom_violation = 1'b0;
  logic [1:0]  viol_cause = 2'd0;
  logic [15:0] sm_id = 16'd0;
  logic [15:0] inst_pc = 16'd0;
  logic        gie = 1'b1;
  logic        viol_irq, viol_reset_req;

  omsp_atom_violation_log_if bus();

  omsp_atom_violation_log #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .atom_violation(atom_violation),
    .viol_cause(viol_cause), .sm_id(sm_id), .inst_pc(inst_pc), .gie(gie),
    .per_bus(bus), .viol_irq(viol_irq), .viol_reset_req(viol_reset_req)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int rr_cnt = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [1:0] cause; logic [15:0] smid; logic [15:0] pc; } rec_t;
  rec_t q[$];
  bit m_vd, m_ovf, m_irq_en, m_rst_en, m_rr;
  int m_drop, m_win, m_max;

  always @(posedge mclk or posedge puc_rst) begin
    bit   ev, wr, dropped;
    int   off;
    rec_t r;
    if (puc_rst) begin
      q.delete();
      m_vd = 0; m_ovf = 0; m_irq_en = 0; m_rst_en = 0; m_rr = 0;
      m_drop = 0; m_win = 0; m_max = 0;
    end else begin
      ev   = atom_violation && !m_vd;
      m_vd = atom_violation;
      wr   = bus.per_en && (bus.per_we != 2'b00);
      off  = int'(bus.per_addr) - int'(BASE);
      m_rr = ev && m_rst_en;
      if (wr && off == 5 && q.size() > 0) void'(q.pop_front());
      dropped = 0;
      if (ev) begin
        if (q.size() < DEPTH) begin
          r.cause = viol_cause; r.smid = sm_id; r.pc = inst_pc;
          q.push_back(r);
        end else dropped = 1;
      end
      if (wr && off == 1) begin
        m_irq_en = bus.per_din[0];
        m_rst_en = bus.per_din[1];
        if (bus.per_din[2]) begin m_ovf = 0; m_drop = 0; end
      end
      if (dropped) begin
        m_ovf = 1;
        if (m_drop < 15) m_drop++;
      end
`ifdef ATOM_LOG_MAXWIN_EN
      if (!gie) begin
        if (m_win < 65535) m_win++;
      end else begin
        if (m_win > m_max) m_max = m_win;
        m_win = 0;
      end
      if (wr && off == 6) m_max = 0;
`endif
    end
  end

  function automatic logic [15:0] exp_dout();
    int off;
    logic [15:0] d;
    d = 16'd0;
    off = int'(bus.per_addr) - int'(BASE);
    if (bus.per_en && bus.per_we == 2'b00 && off >= 0 && off < 8) begin
      case (off)
        0: d = 16'(q.size() + (m_ovf ? 16 : 0) + m_drop * 32 +
                   (m_irq_en ? 512 : 0) + (m_rst_en ? 1024 : 0));
        1: d = 16'((m_irq_en ? 1 : 0) + (m_rst_en ? 2 : 0));
        2: d = (q.size() > 0) ? 16'(q[0].cause) : 16'd0;
        3: d = (q.size() > 0) ? q[0].smid : 16'd0;
        4: d = (q.size() > 0) ? q[0].pc : 16'd0;
        6: d = 16'(m_max);
        default: d = 16'd0;
      endcase
    end
    return d;
  endfunction

  // Per-cycle compare against the model
  always @(negedge mclk) begin
    if (chk_en && !puc_rst) begin
      chk("irq", {15'd0, viol_irq}, {15'd0, m_irq_en && q.size() != 0});
      chk("reset_req", {15'd0, viol_reset_req}, {15'd0, m_rr});
      chk("per_dout", bus.per_dout, exp_dout());
      rr_cnt += int'(viol_reset_req);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic bus_wr(input int off, input logic [15:0] d);
    bus.per_en = 1'b1; bus.per_we = 2'b11;
    bus.per_addr = BASE + 14'(off); bus.per_din = d;
    tick();
    bus.per_en = 1'b0; bus.per_we = 2'b00;
  endtask

  task automatic expect_reg(input string nm, input int off, input logic [15:0] exp);
    logic [15:0] v;
    bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = BASE + 14'(off);
    @(negedge mclk);
    v = bus.per_dout;
    chk(nm, v, exp);
    tick();
    bus.per_en = 1'b0;
  endtask

  task automatic event_pulse(input logic [1:0] c, input logic [15:0] s,
                             input logic [15:0] p, input int hold);
    viol_cause = c; sm_id = s; inst_pc = p;
    atom_violation = 1'b1;
    repeat (hold) tick();
    atom_violation = 1'b0;
    tick();
  endtask

  task automatic event_with_pop(input logic [1:0] c, input logic [15:0] s, input logic [15:0] p);
    viol_cause = c; sm_id = s; inst_pc = p;
    atom_violation = 1'b1;
    bus.per_en = 1'b1; bus.per_we = 2'b11; bus.per_addr = BASE + 14'd5; bus.per_din = 16'd0;
    tick();
    bus.per_en = 1'b0; bus.per_we = 2'b00;
    atom_violation = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr0;
    logic [15:0] pcs [4];
    bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = 14'd0; bus.per_din = 16'd0;

    // Reset state
    repeat (3) tick();
    puc_rst = 1'b0;
    tick();
    chk_en = 1;
    expect_reg("reset_status", 0, 16'h0000);
    chk("reset_irq", {15'd0, viol_irq}, 16'd0);
    chk("reset_rreq", {15'd0, viol_reset_req}, 16'd0);

    // Single violation held 3 cycles
    bus_wr(1, 16'h0003);
    chk("irq_empty", {15'd0, viol_irq}, 16'd0);
    rr0 = rr_cnt;
    viol_cause = 2'b10; sm_id = 16'h0005; inst_pc = 16'hA01C;
    atom_violation = 1'b1;
    tick();
    @(negedge mclk);
    chk("irq_rise", {15'd0, viol_irq}, 16'd1);
    chk("rreq_rise", {15'd0, viol_reset_req}, 16'd1);
    tick(); tick();
    atom_violation = 1'b0;
    tick(); tick();
    chk("rreq_pulses", 16'(rr_cnt - rr0), 16'd1);
    expect_reg("single_status", 0, 16'h0601);
    expect_reg("single_cause", 2, 16'h0002);
    expect_reg("single_smid", 3, 16'h0005);
    expect_reg("single_pc", 4, 16'hA01C);

    // Overflow: 6 events into an empty 4-deep FIFO
    bus_wr(5, 16'h0000);
    bus_wr(1, 16'h0001);
    for (int i = 0; i < 6; i++)
      event_pulse(2'((i + 1) % 4), 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1);
    expect_reg("ovf_status", 0, 16'h0254);
    expect_reg("ovf_head_cause", 2, 16'h0001);
    expect_reg("ovf_head_smid", 3, 16'h0100);
    expect_reg("ovf_head_pc", 4, 16'h1000);
    bus_wr(1, 16'h0005);
    expect_reg("clr_status", 0, 16'h0204);

    // Full FIFO: event and pop together
    event_with_pop(2'b11, 16'h0BEE, 16'hBEEF);
    expect_reg("fullpop_status", 0, 16'h0204);
    expect_reg("fullpop_head", 4, 16'h1001);

    // Drain in order
    pcs[0] = 16'h1001; pcs[1] = 16'h1002; pcs[2] = 16'h1003; pcs[3] = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      expect_reg("drain_pc", 4, pcs[k]);
      bus_wr(5, 16'h0000);
    end
    @(negedge mclk);
    chk("drain_irq_low", {15'd0, viol_irq}, 16'd0);
    tick();
    expect_reg("drain_status", 0, 16'h0200);
    expect_reg("empty_cause", 2, 16'h0000);
    expect_reg("empty_smid", 3, 16'h0000);
    expect_reg("empty_pc", 4, 16'h0000);
    bus_wr(5, 16'h0000);
    expect_reg("extra_pop_status", 0, 16'h0200);

    // Empty FIFO: event and pop together
    event_with_pop(2'b10, 16'h0042, 16'h4242);
    expect_reg("emptypop_status", 0, 16'h0201);
    expect_reg("emptypop_pc", 4, 16'h4242);
    bus_wr(5, 16'h0000);

    // Masked window tracking
    bus_wr(6, 16'h0000);
    gie = 1'b0; repeat (37) tick();
    gie = 1'b1; repeat (3) tick();
    gie = 1'b0; repeat (12) tick();
    gie = 1'b1; tick();
`ifdef ATOM_LOG_MAXWIN_EN
    expect_reg("maxwin", 6, 16'd37);
`else
    expect_reg("maxwin", 6, 16'd0);
`endif
    bus_wr(6, 16'h0001);
    expect_reg("maxwin_clr", 6, 16'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      atom_violation = ($urandom % 3) == 0;
      viol_cause = 2'($urandom);
      sm_id = 16'($urandom);
      inst_pc = 16'($urandom);
      if (($urandom % 12) == 0) gie = ~gie;
      bus.per_en = ($urandom % 2) == 1;
      bus.per_we = (($urandom % 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.per_addr = BASE - 14'd2 + 14'($urandom_range(0, 11));
      bus.per_din = 16'($urandom);
      tick();
    end
    atom_violation = 1'b0; gie = 1'b1;
    bus.per_en = 1'b0; bus.per_we = 2'b00;
    tick(); tick();

    // Reset in the middle of operation
    bus_wr(1, 16'h0004);
    repeat (8) bus_wr(5, 16'h0000);
    bus_wr(1, 16'h0003);
    event_pulse(2'b01, 16'h0011, 16'h2000, 1);
    event_pulse(2'b10, 16'h0022, 16'h2002, 2);
    event_pulse(2'b11, 16'h0033, 16'h2004, 1);
    expect_reg("pre_reset_status", 0, 16'h0603);
    bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = BASE;
    @(posedge mclk);
    #3 puc_rst = 1'b1;
    #1;
    chk("midrst_status", bus.per_dout, 16'h0000);
    chk("midrst_irq", {15'd0, viol_irq}, 16'd0);
    chk("midrst_rreq", {15'd0, viol_reset_req}, 16'd0);
    bus.per_en = 1'b0;
    tick();
    puc_rst = 1'b0;
    tick();
    expect_reg("post_reset_status", 0, 16'h0000);
    expect_reg("post_reset_pc", 4, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/omsp_atom_violation_log.md
# omsp_atom_violation_log

Peripheral-mapped logger sitting directly downstream of the atomicity monitor. It consumes the monitor's `atom_violation` and effective `gie` outputs, and captures each violation into a small FIFO of records (cause, active SM ID, PC). It raises an interrupt and/or a reset request toward the clock/reset module. Optionally, it tracks the longest interrupt-masked window. Software accesses it over the standard openMSP430 peripheral bus.

## Interface
- `BASE_ADDR`, 14'h00C8, word address of the 8-word register window
- `DEPTH`, 4, FIFO entries (power of two, 2..8)
- `mclk`  in  1  system clock; the only clock
- `puc_rst`  in  1  asynchronous, active-high reset
- `atom_violation`  in  1  violation flag from the atomicity monitor
- `viol_cause`  in  2  cause qualifier, valid with `atom_violation`: 01 clix nesting, 10 clix bound exceeded, 11 SM-entry nesting, 00 unspecified
- `sm_id`  in  16  ID of the currently executing SM (0 = unprotected)
- `inst_pc`  in  16  PC of the instruction in execution
- `gie`  in  1  effective interrupt enable from the atomicity monitor
- `per_addr`  in  14  peripheral word address
- `per_din`  in  16  peripheral write data
- `per_en`  in  1  peripheral access strobe
- `per_we`  in  2  byte write enables; any nonzero value counts as a write
- `per_dout`  out  16  peripheral read data
- `viol_irq`  out  1  level interrupt request
- `viol_reset_req`  out  1  one-cycle reset request pulse

## Operation
- Event detection: an event is a rising edge of `atom_violation` (`atom_violation & ~viol_d`, where `viol_d` is registered). A violation held high for several cycles is one event.
- Push: on an event with the FIFO not full, store `{viol_cause, sm_id, inst_pc}` sampled in the event cycle.
- Overflow: on an event with the FIFO full, drop the record, set sticky `OVF`, and increment `DROP[3:0]` (saturates at 15).
- Pop: a write to POP with the FIFO non-empty removes the head entry. A pop with the FIFO empty is ignored.
- Simultaneous push and pop:
  - FIFO full: the pop frees a slot, the push is accepted, no overflow.
  - FIFO empty: the pop is ignored and the push is stored (count = 1).
- Register map (offsets from `BASE_ADDR`):
  - +0 STATUS (RO): [3:0] count, [4] `OVF`, [8:5] `DROP`, [9] `IRQ_EN`, [10] `RST_EN`.
  - +1 CTRL (RW): [0] `IRQ_EN`, [1] `RST_EN`; writing 1 to [2] clears `OVF` and `DROP` (self-clearing, reads 0).
  - +2 HEAD_CAUSE: [1:0] cause.
  - +3 HEAD_SMID.
  - +4 HEAD_PC.
  - +5 POP: write-only, reads 0.
  - +6 MAXWIN: read returns the longest masked window; any write clears it.
  - +7 reserved: reads 0.
- Head registers (+2..+4) read 0 when the FIFO is empty. Reads are non-destructive.
- Reads are combinational: `per_dout` = selected register when `per_en` is high, no write, and the address is in the window; otherwise 0.
- `viol_irq` = `IRQ_EN & (count != 0)`.
- `viol_reset_req` pulses when `RST_EN` is set at an event, whether the record was stored or dropped.
- Pointer arithmetic wraps modulo `DEPTH`. Count is held separately so full and empty are unambiguous.

## Timing
- Reset (asynchronous) clears: FIFO (count 0, pointers 0), `OVF`, `DROP`, CTRL, MAXWIN, the window counter and `viol_d`. Outputs go to `per_dout` = 0, `viol_irq` = 0, `viol_reset_req` = 0.
- Reset mid-operation discards all records.
- Push latency: a record sampled in event cycle N is readable and counted from cycle N+1. `viol_irq` rises in cycle N+1.
- `viol_reset_req` is registered: high for exactly cycle N+1.
- A pop written in cycle N takes effect in cycle N+1. `viol_irq` falls in N+1 if the count reaches 0.
- A CTRL write in cycle N affects an event in cycle N+1 onward. An event in cycle N uses the old `RST_EN`.
- Window counter:
  - increments each cycle with `gie` = 0, saturating at 16'hFFFF;
  - on the cycle `gie` returns to 1, MAXWIN takes max(MAXWIN, counter) and the counter resets to 0.
  - A MAXWIN write in the same cycle as an update wins (result 0).

## Configuration
- `ATOM_LOG_MAXWIN_EN` defined: the window counter and MAXWIN logic are built as described.
- `ATOM_LOG_MAXWIN_EN` undefined: no counter, MAXWIN reads 0, writes to it are ignored. All other behaviour is identical.

## Test plan
- Reset, then single violation: CTRL = 3; pulse `atom_violation` for 3 cycles with cause 2'b10, `sm_id` 16'h0005, `inst_pc` 16'hA01C.
  - Expect count 1 and head = {2, 5, A01C}.
  - Expect `viol_irq` = 1 from the next cycle and exactly one 1-cycle `viol_reset_req`.
- Overflow: 6 separate events with `DEPTH` = 4.
  - Expect count 4, `OVF` = 1, `DROP` = 2, and the head equal to the first event's record.
  - Write CTRL[2] = 1: `OVF` and `DROP` read 0, count stays 4.
- Drain: 4 POP writes.
  - Expect records in order, count reaching 0, `viol_irq` = 0 the cycle after the last pop, and head registers reading 0.
  - A 5th POP leaves count at 0.
- Simultaneous events:
  - Full FIFO, event and POP in the same cycle: count stays 4, no `OVF`, newest record at the tail.
  - Empty FIFO, same stimulus: count 1.
- MAXWIN (macro defined): drive `gie` low for 37 cycles, then low for 12 cycles.
  - Expect MAXWIN = 37. A write clears it to 0.
  - With the macro undefined, MAXWIN always reads 0.
- Reset mid-operation: assert `puc_rst` with 3 records queued and CTRL = 3.
  - All STATUS fields read 0 and both outputs are low immediately.
